// File: rtl/plic_gateway_pkg.sv
// Shared PLIC definitions: tree widths, gateway defaults and the gateway state encoding.
package plic_gateway_pkg;

    localparam int PLIC_IRQ_NUM   = 31;
    localparam int PLIC_IRQ_WIDTH = $clog2(PLIC_IRQ_NUM + 1);
    localparam int PLIC_LEV_WIDTH = 3;
    localparam int PLIC_MAX_PEND  = 7;

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_BUSY = 2'd2
    } gw_state_e;

endpackage

// File: rtl/plic_sync2.sv
// Two-flop reset-to-0 synchroniser for asynchronous PLIC inputs.
module plic_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // NOTE: flops use non-blocking assignments so both stages sample the pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/plic_gateway.sv
// Per-source PLIC gateway: turns a level or edge interrupt into one pending request
// and holds it off while the target is servicing the source.
module plic_gateway
    import plic_gateway_pkg::*;
#(
    parameter int unsigned ID        = 1,
    parameter int unsigned MAX_PEND  = PLIC_MAX_PEND,
    parameter int unsigned CNT_WIDTH = $clog2(MAX_PEND + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      src_i,
    input  logic                      edge_i,
    input  logic                      en_i,
    input  logic [PLIC_LEV_WIDTH-1:0] prio_i,
    input  logic                      claim_i,
    input  logic                      complete_i,
    output logic                      pend_o,
    output logic                      busy_o,
    output logic [PLIC_LEV_WIDTH-1:0] prio_o,
    output logic [PLIC_IRQ_WIDTH-1:0] id_o
);

    localparam logic [PLIC_IRQ_WIDTH-1:0] ID_VAL  = PLIC_IRQ_WIDTH'(ID);
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX = CNT_WIDTH'(MAX_PEND);

    gw_state_e            state;
    gw_state_e            state_nxt;
    logic                 s_sync;
    logic                 s_prev;
    logic                 rise;
    logic                 req;
    logic                 take;
    logic [CNT_WIDTH-1:0] cnt;

    plic_sync2 u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (src_i),
        .q_o     (s_sync)
    );

    assign rise = s_sync & ~s_prev;
    assign take = (state == GW_PEND) & claim_i;
    assign req  = edge_i ? ((cnt != '0) | rise) : s_sync;

    // A rise and a claim in the same cycle cancel, so the count stays exact.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_prev <= 1'b0;
            cnt    <= '0;
            state  <= GW_IDLE;
        end else begin
            s_prev <= s_sync;
            state  <= state_nxt;
            if (!edge_i) begin
                cnt <= '0;
            end else if (rise && !take) begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_WIDTH'(1);
            end else if (take && !rise) begin
                if (cnt != '0) cnt <= cnt - CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: next-state is defaulted to the current state first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            GW_IDLE: if (req) state_nxt = GW_PEND;
            GW_PEND: begin
                if (claim_i)                state_nxt = GW_BUSY;
                else if (!edge_i && !s_sync) state_nxt = GW_IDLE;
            end
            GW_BUSY: if (complete_i) state_nxt = GW_IDLE;
            default: state_nxt = GW_IDLE;
        endcase
    end

    assign pend_o = (state == GW_PEND);
    assign busy_o = (state == GW_BUSY);
    assign prio_o = (pend_o && en_i) ? prio_i : '0;
    assign id_o   = ID_VAL;

endmodule

// File: tb/tb_plic_gateway.sv
// Directed self-checking bench for plic_gateway (ID = 3, MAX_PEND = 7).
module tb_plic_gateway;
    import plic_gateway_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      src = 1'b0;
    logic                      edge_mode = 1'b0;
    logic                      en = 1'b1;
    logic [PLIC_LEV_WIDTH-1:0] prio = 3'd5;
    logic                      claim = 1'b0;
    logic                      complete = 1'b0;
    logic                      pend;
    logic                      busy;
    logic [PLIC_LEV_WIDTH-1:0] prio_out;
    logic [PLIC_IRQ_WIDTH-1:0] id;

    int n_tests = 0;
    int n_fail  = 0;

    plic_gateway #(.ID(3), .MAX_PEND(7)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .src_i      (src),
        .edge_i     (edge_mode),
        .en_i       (en),
        .prio_i     (prio),
        .claim_i    (claim),
        .complete_i (complete),
        .pend_o     (pend),
        .busy_o     (busy),
        .prio_o     (prio_out),
        .id_o       (id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            src = 1'b1; tick(); tick();
            src = 1'b0; tick(); tick();
        end
    endtask

    // Claims and completes every request the gateway presents within a cycle budget.
    task automatic service_all(output int n);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (pend) begin
                claim = 1'b1; tick(); claim = 1'b0;
                if (busy) n++;
                complete = 1'b1; tick(); complete = 1'b0;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        #3;
        check("rst_pend", pend, 0);
        check("rst_busy", busy, 0);
        check("rst_prio", prio_out, 0);
        check("rst_id", id, 3);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Level request and mid-PEND asynchronous reset
        src = 1'b1;
        tick(); tick();
        check("lvl_lat_n1", pend, 0);
        tick();
        check("lvl_lat_n2", pend, 1);
        check("lvl_prio", prio_out, 5);
        check("lvl_id", id, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pend", pend, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_prio", prio_out, 0);
        tick(); tick();
        check("held_rst_pend", pend, 0);
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_n1", pend, 0);
        tick();
        check("post_rst_n2", pend, 1);

        // Claim / complete with the level still asserted
        claim = 1'b1; tick(); claim = 1'b0;
        check("claim_busy", busy, 1);
        check("claim_pend", pend, 0);
        check("claim_prio", prio_out, 0);
        tick();
        check("busy_hold", busy, 1);
        complete = 1'b1; tick(); complete = 1'b0;
        check("cmpl_busy", busy, 0);
        check("cmpl_pend", pend, 0);
        tick();
        check("repend", pend, 1);

        // Return to idle with the line low
        claim = 1'b1; tick(); claim = 1'b0;
        src = 1'b0;
        complete = 1'b1; tick(); complete = 1'b0;
        tick(); tick(); tick();
        check("idle_pend", pend, 0);
        check("idle_busy", busy, 0);

        // Claim and complete in IDLE are ignored
        claim = 1'b1; complete = 1'b1; tick(); claim = 1'b0; complete = 1'b0;
        check("idle_ign_pend", pend, 0);
        check("idle_ign_busy", busy, 0);

        // Level withdrawn before claim
        src = 1'b1;
        tick(); tick(); tick(); tick();
        check("wd_pend", pend, 1);
        src = 1'b0;
        tick();
        check("wd_f0", pend, 1);
        tick();
        check("wd_f1", pend, 1);
        tick();
        check("wd_f2_pend", pend, 0);
        check("wd_f2_busy", busy, 0);

        // Edge mode: three pulses give three service periods
        edge_mode = 1'b1;
        tick();
        pulses(3);
        check("edge_pend", pend, 1);
        complete = 1'b1; tick(); complete = 1'b0;
        check("pend_cmpl_ign_pend", pend, 1);
        check("pend_cmpl_ign_busy", busy, 0);
        service_all(n);
        check("edge_services", n, 3);
        check("edge_end_pend", pend, 0);
        check("edge_end_busy", busy, 0);

        // Saturation at MAX_PEND
        pulses(10);
        check("sat_pend", pend, 1);
        service_all(n);
        check("sat_services", n, 7);
        check("sat_end_pend", pend, 0);

        // Rise coincident with claim (complete also asserted and ignored)
        pulses(2);
        check("sim_pend", pend, 1);
        src = 1'b1;
        tick(); tick();
        claim = 1'b1; complete = 1'b1;
        tick();
        claim = 1'b0; complete = 1'b0;
        check("sim_busy", busy, 1);
        check("sim_pend_lo", pend, 0);
        src = 1'b0;
        complete = 1'b1; tick(); complete = 1'b0;
        service_all(n);
        check("sim_services", n, 2);
        check("sim_end_busy", busy, 0);

        // Enable masking and zero priority
        edge_mode = 1'b0;
        prio = 3'd6;
        en = 1'b0;
        src = 1'b1;
        tick(); tick(); tick();
        check("mask_pend", pend, 1);
        check("mask_prio", prio_out, 0);
        en = 1'b1;
        #1;
        check("unmask_prio", prio_out, 6);
        prio = 3'd0;
        #1;
        check("zero_prio", prio_out, 0);
        check("zero_prio_pend", pend, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
- Per-source PLIC interrupt gateway: the source side of the priority-selection tree.
- Synchronises a raw interrupt line and converts level or edge requests into a single pending request.
- Enforces the claim/complete handshake so a source cannot re-request while it is being serviced.
- Drives one (priority, id) leaf of the priority tree; the top generates `PLIC_IRQ_NUM instances.

Parameters:
- ID, 1, source id driven on id_o; 0 is reserved for "no interrupt".
- MAX_PEND, 7, saturation limit of the edge-request counter; must be ≥1.
- CNT_WIDTH, $clog2(MAX_PEND+1), width of the edge counter (derived).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- src_i  in  1  raw interrupt line, asynchronous to clk_i.
- edge_i  in  1  1 = rising-edge triggered, 0 = level (active-high) triggered.
- en_i  in  1  target enable for this source; masks prio_o only, not pending capture.
- prio_i  in  `PLIC_LEV_WIDTH  configured source priority.
- claim_i  in  1  one-cycle pulse: the target claimed this id.
- complete_i  in  1  one-cycle pulse: the target wrote complete for this id.
- pend_o  in/out: out  1  pending bit (readable via the pending register).
- busy_o  out  1  claimed, awaiting complete.
- prio_o  out  `PLIC_LEV_WIDTH  prio_i when pend_o & en_i, else 0.
- id_o  out  `PLIC_IRQ_WIDTH  constant ID.

Behaviour:
- Reset (rst_n_i low, async):
  - sync flops, previous-sample flop and counter = 0.
  - State = IDLE.
  - pend_o = 0, busy_o = 0, prio_o = 0.
  - id_o = ID at all times.
- Synchroniser: 2 flops on src_i give s_sync.
  - s_prev is s_sync delayed one cycle.
  - rise = s_sync & ~s_prev.
- Edge counter (active only when edge_i = 1):
  - +1 on rise.
  - −1 on the PEND→BUSY transition.
  - Both in the same cycle: counter unchanged.
  - Saturates at MAX_PEND; further edges are dropped.
  - Never underflows.
  - Cleared to 0 while edge_i = 0.
- req (combinational):
  - edge_i = 1: req = (cnt != 0) | rise.
  - edge_i = 0: req = s_sync.
- State machine (registered):
  - IDLE: req → PEND.
  - PEND:
    - claim_i → BUSY.
    - Level mode with s_sync = 0 and no claim → IDLE (level withdrawn before claim).
  - BUSY:
    - complete_i → IDLE.
    - IDLE re-evaluates req on the next cycle, so re-pend is ≥1 cycle after complete.
- Outputs decoded from state:
  - pend_o = (state == PEND).
  - busy_o = (state == BUSY).
  - prio_o combinational from pend_o, en_i, prio_i.
- Latency:
  - src_i high before clk edge N (meeting setup) → pend_o high after edge N+2.
  - Same latency in edge mode.
  - claim_i at edge M → pend_o low after M.
  - complete_i at edge C → busy_o low after C; pend_o high again after C+1 if req is still true.
- Ignored inputs:
  - claim_i outside PEND.
  - complete_i outside BUSY.
  - claim_i and complete_i asserted together in PEND: claim taken, complete ignored.
- Edges in BUSY are still counted, up to saturation.
- prio_i = 0 yields prio_o = 0, so the source never wins the tree; the pending state still tracks normally.
- en_i = 0 does not block capture; pending is presented once en_i returns to 1.
- Changing edge_i in PEND/BUSY: state is kept and the counter is cleared when edge_i = 0. Software changes mode only in IDLE.

Decomposition:
- Gateway state enum (IDLE/PEND/BUSY, 2 bits) and the MAX_PEND default go in the shared PLIC define/package alongside `PLIC_LEV_WIDTH/`PLIC_IRQ_WIDTH.
- One sub-module, plic_sync2: 2-flop reset-to-0 synchroniser built from the existing register primitives; reused by any other async PLIC input.

Test Plan:
- Reset: hold rst_n_i low mid-PEND with src_i = 1 → pend_o/busy_o/prio_o = 0 asynchronously, counter = 0; after release with src_i = 1 in level mode, pend_o = 1 three edges later.
- Level: edge_i = 0, prio_i = 5, en_i = 1, src_i = 1 → prio_o = 5, id_o = ID; claim → prio_o = 0, busy_o = 1; complete with src_i still 1 → pend_o = 1 one cycle later.
- Level withdrawn: src_i high 4 cycles then low before claim → pend_o falls 3 cycles after src_i falls; no BUSY entry.
- Edge counting: edge_i = 1, 3 pulses (2 cycles high, 2 low) → pend_o = 1, cnt = 3; then claim, complete, claim, complete, claim, complete → exactly 3 BUSY periods, then IDLE with cnt = 0.
- Saturation and simultaneity: 10 edges with MAX_PEND = 7 → cnt = 7; rise coincident with claim → cnt unchanged; claim_i in IDLE and complete_i in PEND → no state change.
- Masking: en_i = 0 with source pending → prio_o = 0, pend_o = 1; en_i → 1 gives prio_o = prio_i the same cycle; prio_i = 0 → prio_o = 0.
